prog_loader: RTL and testbench

Boot-time program loader that writes the 16-bit instruction memory behind the MCU fetch port from a byte stream. It is the write side of the program store: it accepts a framed image over a byte valid/ready interface, assembles big-endian 16-bit words, and issues single-cycle writes at consecutive 10-bit addresses starting at 0. It holds the CPU in reset (`cpu_hold`) until a complete image with a correct checksum has been written.

---
 rtl/loader_pkg.sv | 31 +++
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the boot-time program loader:
//               loader FSM state encoding, instruction-memory geometry
//               and the default frame start marker.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Instruction-memory geometry (word address width, word width)
    localparam int          LOADER_ADDR_W = 10;
    localparam int          WORD_W        = 16;

    // Default frame start marker
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SYNC    = 4'd1,
        S_CNT_HI  = 4'd2,
        S_CNT_LO  = 4'd3,
        S_DATA_HI = 4'd4,
        S_DATA_LO = 4'd5,
        S_CHECK   = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } loader_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot-time program loader. Receives a framed image over a
//               byte valid/ready stream (SYNC, CNT_HI, CNT_LO, N big-endian
//               words, XOR checksum), writes each word to consecutive
//               instruction-memory addresses from 0, and keeps the CPU in
//               reset until a complete, checksum-correct image is loaded.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start               - begin a load (IDLE/DONE/ERR only)
//               rx_valid/rx_data    - incoming byte stream
//               rx_ready            - byte accepted when valid && ready
//               wr_en/wr_addr/wr_data - registered memory write port
//               cpu_hold            - CPU held in reset while high
//               busy/done/err       - load status (done/err sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = LOADER_ADDR_W,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [WORD_W-1:0]  wr_data,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    loader_state_t       r_state;
    loader_state_t       w_state_next;

    logic                w_busy;
    logic                w_acc;
    logic                w_last;
    logic                w_start_ok;
    logic [ADDR_W-1:0]   w_last_idx;

    logic [ADDR_W-1:0]   r_addr;     // address of the next word to write
    logic [ADDR_W-1:0]   r_cnt;      // word count; 0 encodes 2^ADDR_W
    logic [1:0]          r_cnt_hi;
    logic [7:0]          r_hi;
    logic [7:0]          r_xor;

    assign w_acc      = rx_valid && w_busy;
    assign rx_ready   = w_busy;
    assign busy       = w_busy;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERR));

    // Index of the final word. Modular subtraction maps count 0 to the
    // all-ones address, so a full-memory image needs no special case.
    assign w_last_idx = r_cnt - ADDR_W'(1);
    assign w_last     = (r_addr == w_last_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_state_next = S_SYNC;
            end
            S_SYNC: begin
                w_busy = 1'b1;
                // Anything other than the marker is line noise; drop it.
                if (rx_valid && (rx_data == SYNC_BYTE)) w_state_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                w_busy = 1'b1;
                if (rx_valid) begin
                    w_state_next = (rx_data[7:2] != 6'd0) ? S_ERR : S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                w_busy = 1'b1;
                if (rx_valid) w_state_next = S_DATA_HI;
            end
            S_DATA_HI: begin
                w_busy = 1'b1;
                if (rx_valid) w_state_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                w_busy = 1'b1;
                if (rx_valid) w_state_next = w_last ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                w_busy = 1'b1;
                if (rx_valid) w_state_next = (rx_data == r_xor) ? S_DONE : S_ERR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, write port and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_cnt    <= '0;
            r_cnt_hi <= 2'd0;
            r_hi     <= 8'd0;
            r_xor    <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (w_start_ok) begin
                r_addr   <= '0;
                r_hi     <= 8'd0;
                r_xor    <= 8'd0;
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (w_acc) begin
                case (r_state)
                    S_CNT_HI: begin
                        r_cnt_hi <= rx_data[1:0];
                        if (rx_data[7:2] != 6'd0) err <= 1'b1;
                    end
                    S_CNT_LO: begin
                        r_cnt <= ADDR_W'({r_cnt_hi, rx_data});
                    end
                    S_DATA_HI: begin
                        r_hi  <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                    end
                    S_DATA_LO: begin
                        r_xor   <= r_xor ^ rx_data;
                        wr_en   <= 1'b1;
                        wr_addr <= r_addr;
                        wr_data <= {r_hi, rx_data};
                        r_addr  <= r_addr + ADDR_W'(1);
                    end
                    S_CHECK: begin
                        if (rx_data == r_xor) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Stimulus pushes the
//               expected memory writes into a queue; a monitor pops and
//               compares on every wr_en. Status flags are checked directly
//               at the end of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    logic [25:0] exp_q[$];

    prog_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {6'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                check("write", {6'd0, wr_addr, wr_data}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_w(input logic [9:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic two_word_frame(input logic [7:0] chk);
        push_w(10'd0, 16'h1234);
        push_w(10'd1, 16'hABCD);
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(chk);
    endtask

    task automatic drain(input string name);
        repeat (2) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check("rst_rx_ready", rx_ready, 0);
        check("rst_wr_en",    wr_en,    0);
        check("rst_wr_addr",  wr_addr,  0);
        check("rst_wr_data",  wr_data,  0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_err",      err,      0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good two-word frame, CHK = 0x40
        pulse_start();
        check("busy_after_start", busy, 1);
        check("ready_after_start", rx_ready, 1);
        two_word_frame(8'h40);
        check("good_done", done, 1);
        check("good_err", err, 0);
        check("good_hold", cpu_hold, 0);
        check("good_busy", busy, 0);
        drain("good_drain");

        // Bad checksum: writes still happen, err sticky, CPU held
        pulse_start();
        check("restart_clears_done", done, 0);
        check("restart_sets_hold", cpu_hold, 1);
        two_word_frame(8'h41);
        check("bad_err", err, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        drain("bad_drain");

        // Recovery with a good frame
        pulse_start();
        check("recover_err_clr", err, 0);
        two_word_frame(8'h40);
        check("recover_done", done, 1);
        check("recover_err", err, 0);
        drain("recover_drain");

        // Garbage before the marker
        pulse_start();
        send(8'h00); send(8'hFF); send(8'h5A);
        push_w(10'd0, 16'hBEEF);
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'hBE); send(8'hEF); send(8'h51);
        check("garbage_done", done, 1);
        check("garbage_hold", cpu_hold, 0);
        drain("garbage_drain");

        // Illegal CNT_HI
        pulse_start();
        send(8'hA5); send(8'h04);
        check("cnthi_err", err, 1);
        check("cnthi_busy", busy, 0);
        check("cnthi_done", done, 0);
        check("cnthi_hold", cpu_hold, 1);
        drain("cnthi_drain");

        // Full 1024-word image, word i = i, CHK = 0x00
        pulse_start();
        send(8'hA5); send(8'h00); send(8'h00);
        for (int i = 0; i < 1024; i++) begin
            push_w(10'(i), 16'(i));
            send(8'(i >> 8));
            send(8'(i & 255));
        end
        check("full_not_done_yet", done, 0);
        check("full_busy_at_check", busy, 1);
        send(8'h00);
        check("full_done", done, 1);
        check("full_err", err, 0);
        drain("full_drain");

        // start while in DATA_HI is ignored
        pulse_start();
        push_w(10'd0, 16'h1234);
        push_w(10'd1, 16'hABCD);
        send(8'hA5); send(8'h00); send(8'h02);
        pulse_start();
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'h40);
        check("ign_start_done", done, 1);
        drain("ign_start_drain");

        // Reset after 3 of 5 words
        pulse_start();
        send(8'hA5); send(8'h00); send(8'h05);
        for (int k = 0; k < 3; k++) begin
            push_w(10'(k), 16'h0100 + 16'(k));
            send(8'h01);
            send(8'(k));
        end
        #6;
        check("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", rx_ready, 0);
        check("mid_rst_hold", cpu_hold, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01); send(8'h03); send(8'h01); send(8'h04); send(8'h05);
        check("post_rst_done", done, 0);
        check("post_rst_err", err, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_hold", cpu_hold, 1);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
